// File: rtl/sipo_deserializer.sv
// sipo_deserializer
//
// Receive side of a shift-register serial link. Serial bits arrive one per
// clock on which s_en is high. They are gathered into WIDTH-bit words. Each
// finished word is offered to a parallel consumer through a valid/ready
// handshake. A sync strobe realigns the word boundary. A sticky overrun flag
// records any finished word that was thrown away because the consumer had
// not yet taken the previous one.
//
// Parameters
//   WIDTH      word length in bits (2 or more)
//   MSB_FIRST  1: first received bit ends up in p_data[WIDTH-1]
//              0: first received bit ends up in p_data[0]
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous, active-low reset
//   s_in     serial data bit
//   s_en     bit strobe; s_in is sampled only when this is high
//   s_sync   marks s_in as bit 0 of a new word (only looked at with s_en)
//   p_data   assembled word; held stable while p_valid is high
//   p_valid  p_data holds a word the consumer has not taken yet
//   p_ready  consumer takes p_data on an edge where p_valid is also high
//   bit_cnt  number of bits collected toward the current word
//   overrun  sticky flag: a finished word was dropped
//   ovr_clr  synchronous clear of overrun
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_in,
    input  logic                     s_en,
    input  logic                     s_sync,
    output logic [WIDTH-1:0]         p_data,
    output logic                     p_valid,
    input  logic                     p_ready,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     overrun,
    input  logic                     ovr_clr
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [CW-1:0]    idx;
    logic             word_done;
    logic             can_load;
    logic             accept;

    // A sync bit always counts as bit 0. Any partial word is then abandoned.
    // Old bits stay in the shift register, but WIDTH new shifts push them all
    // out before the word is complete, so no extra clearing is needed.
    // can_load is high when the output register is free or is being emptied
    // on this same edge.
    always_comb begin
        idx       = s_sync ? '0 : bit_cnt;
        shift_d   = shift_q;
        if (MSB_FIRST) begin
            shift_d = {shift_q[WIDTH-2:0], s_in};
        end else begin
            shift_d = {s_in, shift_q[WIDTH-1:1]};
        end
        word_done = s_en && (idx == LAST_IDX);
        accept    = p_valid && p_ready;
        can_load  = !p_valid || p_ready;
    end

    // Bit collection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (s_en) begin
            shift_q <= shift_d;
            bit_cnt <= word_done ? '0 : idx + CW'(1);
        end
    end

    // Output word and handshake.
    // A word that finishes on the same edge as an accept replaces the old
    // word directly, so p_valid stays high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_data  <= '0;
            p_valid <= 1'b0;
        end else if (word_done && can_load) begin
            p_data  <= shift_d;
            p_valid <= 1'b1;
        end else if (accept) begin
            p_valid <= 1'b0;
        end
    end

    // Sticky overrun flag. A drop on the same edge as ovr_clr wins, so a
    // lost word is never hidden by a clear that happens at the same moment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (word_done && !can_load) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Receive-side partner of the shift-register serial link. Collects a serial bit stream, one bit per qualified clock, into WIDTH-bit words and presents each word on a parallel valid/ready output. Supports word realignment through a sync strobe and flags words dropped because the consumer stalled. Sits between a serial shift-register link and any parallel consumer.

Parameters:
WIDTH, 4, word length in bits; legal range is WIDTH >= 2.
MSB_FIRST, 1, 1 means the first received bit lands in p_data[WIDTH-1]; 0 means it lands in p_data[0].

Ports:
clk  input  1  single clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-low reset.
s_in  input  1  serial data bit.
s_en  input  1  bit strobe; s_in is sampled only on edges where s_en=1.
s_sync  input  1  marks s_in as bit 0 of a new word; qualified by s_en.
p_data  output  WIDTH  assembled word; held stable while p_valid=1.
p_valid  output  1  p_data holds an unconsumed word.
p_ready  input  1  consumer accepts p_data on an edge where p_valid=1 and p_ready=1.
bit_cnt  output  clog2(WIDTH)  number of bits collected toward the current word.
overrun  output  1  sticky flag: a completed word was dropped.
ovr_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (reset=0, asynchronous):
  - p_data=0, p_valid=0, bit_cnt=0, overrun=0, internal shift register=0.
  - Deassertion is sampled on clk; the first bit can be accepted on the first edge with reset=1.
- Bit capture (edge with s_en=1):
  - Index idx = 0 if s_sync=1, otherwise idx = bit_cnt.
  - MSB_FIRST=1: shift <= {shift[WIDTH-2:0], s_in}.
  - MSB_FIRST=0: shift <= {s_in, shift[WIDTH-1:1]}.
  - If idx < WIDTH-1: bit_cnt <= idx+1.
  - If idx = WIDTH-1: the word is complete and bit_cnt <= 0 (wrap-around).
- s_en=0: shift and bit_cnt hold. s_sync is ignored when s_en=0.
- s_sync mid-word:
  - The partial word is discarded silently.
  - The sync bit becomes bit 0.
  - No flag is raised.
- Word completion (same edge as the last bit):
  - The completed word is {shift with the last bit inserted}.
  - If p_valid=0, or p_valid=1 and p_ready=1 on this edge: p_data <= completed word and p_valid <= 1.
  - Otherwise: the completed word is dropped, p_data and p_valid hold, and overrun <= 1.
- Latency: p_valid rises after the same clock edge that samples the last bit. A continuous stream with s_en=1 therefore gives one word every WIDTH cycles.
- Handshake:
  - p_valid stays 1 until an edge with p_ready=1.
  - On an accept edge with no simultaneous completion: p_valid <= 0 and p_data holds its last value.
  - Simultaneous accept and completion: the new word loads, p_valid stays 1, and there is no overrun.
  - p_ready while p_valid=0 has no effect.
- overrun:
  - Set by a dropped word; cleared only by ovr_clr=1 or by reset.
  - Drop and ovr_clr on the same edge: set wins, overrun=1.
- Reset asserted mid-word or mid-handshake: all state clears immediately and the partial word is lost.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
1. Reset then MSB order: WIDTH=4, MSB_FIRST=1, p_ready=1; s_sync=1 on the first bit, bits 1,0,1,1 with s_en=1 -> p_data=4'b1011, p_valid high for one cycle after the 4th edge, bit_cnt sequence 1,2,3,0.
2. LSB order: MSB_FIRST=0, same bits 1,0,1,1 -> p_data=4'b1101.
3. Gapped strobe: insert s_en=0 cycles between bits with s_in toggling during the gaps -> same p_data as scenario 1, and bit_cnt holds during the gaps.
4. Realignment: send 1,1, then s_sync=1 with bits 0,1,1,0 -> only one word, p_data=4'b0110, overrun=0.
5. Back-pressure:
   - Set p_ready=0 and stream words 0xA then 0x5 -> p_data stays 0xA, p_valid=1, overrun=1.
   - Raise p_ready -> p_valid drops.
   - Pulse ovr_clr -> overrun=0.
   - Complete a word on the same edge as p_ready=1 -> the new word loads with no overrun.
6. Async reset: assert reset=0 between clock edges after 2 bits, release, send 4 bits 0,1,0,1 -> p_data=4'b0101, and the outputs read 0 immediately on the reset assertion.
